// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider, one quotient bit per clock.
//
// The remainder and quotient registers shift left together. Each step moves
// the next dividend magnitude bit into the remainder and performs one trial
// subtraction of the divisor magnitude. With SIGNED=1 the divide works on
// magnitudes and the signs are applied when the result is written out. The
// quotient truncates toward zero, and the remainder takes the dividend's sign.
//
// Ports:
//   clk_i          system clock, all state on rising edge
//   rst_ni         asynchronous active-low reset
//   start_i        request, sampled only while idle
//   dividend_i     numerator, latched on accepted start
//   divisor_i      denominator, latched on accepted start
//   busy_o         high from the cycle after accept until completion
//   done_o         one-cycle pulse, results valid
//   quotient_o     result, held until next completion
//   remainder_o    result, held until next completion
//   div_by_zero_o  set with done when divisor was 0, held until next completion
module seq_divider #(
    parameter int unsigned WIDTH  = 8,
    parameter bit          SIGNED = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StZero} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [WIDTH:0]  rem_q;
    logic [WIDTH-1:0] quo_q;   // dividend bits still to consume, quotient bits shift in at LSB
    logic [WIDTH-1:0] dvs_q;   // divisor magnitude
    logic            neg_quo_q;
    logic            neg_rem_q;
    logic            busy_q;
    logic            done_q;
    logic            dbz_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] remd_q;

    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH+1:0] rem_shift;
    logic [WIDTH+1:0] trial;
    logic             qbit;
    logic [WIDTH:0]   rem_d;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] quot_res;
    logic [WIDTH-1:0] remd_res;

    always_comb begin
        dvd_neg   = SIGNED && dividend_i[WIDTH-1];
        dvs_neg   = SIGNED && divisor_i[WIDTH-1];
        // The most-negative value maps to 2^(WIDTH-1), which still fits unsigned.
        dvd_mag   = dvd_neg ? -dividend_i : dividend_i;
        dvs_mag   = dvs_neg ? -divisor_i : divisor_i;

        // Partial remainder never reaches 2*divisor, so the top bit of the
        // difference is a reliable sign.
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        trial     = rem_shift - {2'b00, dvs_q};
        qbit      = ~trial[WIDTH+1];
        rem_d     = qbit ? trial[WIDTH:0] : rem_shift[WIDTH:0];
        quo_d     = {quo_q[WIDTH-2:0], qbit};

        quot_res  = neg_quo_q ? -quo_d : quo_d;
        remd_res  = neg_rem_q ? -rem_d[WIDTH-1:0] : rem_d[WIDTH-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            quot_q    <= '0;
            remd_q    <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        busy_q    <= 1'b1;
                        rem_q     <= '0;
                        dvs_q     <= dvs_mag;
                        neg_quo_q <= dvd_neg ^ dvs_neg;
                        neg_rem_q <= dvd_neg;
                        if (divisor_i == '0) begin
                            // Raw dividend is reported as the remainder.
                            quo_q   <= dividend_i;
                            state_q <= StZero;
                        end else begin
                            quo_q   <= dvd_mag;
                            cnt_q   <= CntW'(WIDTH);
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        quot_q  <= quot_res;
                        remd_q  <= remd_res;
                        dbz_q   <= 1'b0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                StZero: begin
                    quot_q  <= '1;
                    remd_q  <= quo_q;
                    dbz_q   <= 1'b1;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign quotient_o    = quot_q;
    assign remainder_o   = remd_q;
    assign div_by_zero_o = dbz_q;

endmodule
